uart_pixel_writer: RTL and testbench
====================================

UART_PIXEL_WRITER -- requirements
Module: uart_pixel_writer

Interface
REQ-001 Parameter H_ACT, 800, active pixels per row (column wrap point).
REQ-002 Parameter V_ACT, 480, active rows per page (row wrap point).
REQ-003 Parameter FIFO_DEPTH, 8, pixel FIFO depth in 16-bit words, power of two.
REQ-004 Parameter CLR_PAGES, 1, pages swept during the power-up clear, range 1..8.
REQ-005 Parameter CLR_VALUE, 16'h0000, RGB565 word written during the clear.
REQ-006 Port clk, input, 1, single clock for all logic.
REQ-007 Port rst, input, 1, reset, synchronous, active-high.
REQ-008 Port rx_data, input, 8, received UART byte.
REQ-009 Port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-010 Port startup_inc, input, 1, one-cycle pulse: the SDRAM write of the current word/address was accepted.
REQ-011 Port FIFO_RD_req, input, 1, pop request for the head word.
REQ-012 Port FIFO_out, output, 16, head word, first-word-fall-through.
REQ-013 Port FIFO_full, output, 1, high when a word is available to the consumer (not a capacity flag).
REQ-014 Port page_set, output, 3, SDRAM page being written.
REQ-015 Port row_add_user, output, 9, write row address.
REQ-016 Port col_add_user, output, 10, write column address.
REQ-017 Port startup, output, 1, high once the clear has completed; stays high until reset.
REQ-018 Port fifo_ovf, output, 1, sticky overflow flag.

Function
REQ-019 The block SHALL implement the states CLEAR, IDLE, PAGE and RUN; reset enters CLEAR.
REQ-020 In CLEAR, FIFO_out SHALL equal CLR_VALUE, FIFO_full SHALL be 1, FIFO_RD_req SHALL be ignored, and rx_valid bytes SHALL be discarded.
REQ-021 In every state, a startup_inc pulse SHALL advance the write address in the same cycle: col+1. At col==H_ACT-1: col=0, row+1. At row==V_ACT-1 with col==H_ACT-1: row=0, and in CLEAR page_set+1.
REQ-022 CLEAR SHALL exit to IDLE on the startup_inc that completes H_ACT*V_ACT*CLR_PAGES writes; page_set, row and col SHALL be 0 and startup SHALL be 1 from the next cycle.
REQ-023 In IDLE, the byte 8'hA5 SHALL move the FSM to PAGE; any other byte SHALL be discarded.
REQ-024 In PAGE, the next byte SHALL load page_set with rx_data[2:0], clear fifo_ovf, and zero the pixel counter, row and col; the FSM then SHALL move to RUN.
REQ-025 In RUN, bytes SHALL pair as high byte then low byte. On the low byte the block SHALL push {high,low}, and the word SHALL be visible on FIFO_out/FIFO_full one cycle after that rx_valid cycle.
REQ-026 RUN SHALL return to IDLE after H_ACT*V_ACT words have been pushed; a pending unpaired high byte SHALL be discarded on that transition.
REQ-027 A push into a FIFO holding FIFO_DEPTH words with no simultaneous pop SHALL drop the word, set fifo_ovf, and still count the pixel.
REQ-028 Simultaneous push and pop SHALL be accepted at any fill level, including full, with the level unchanged.
REQ-029 A pop while empty SHALL be ignored; FIFO_out is don't-care while FIFO_full=0 outside CLEAR.
REQ-030 Word order through the FIFO SHALL be preserved; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-031 Outside CLEAR, the address counters SHALL advance only on startup_inc and never on push or pop.

Reset
REQ-032 With rst high at a clk edge, the block SHALL set: state=CLEAR, startup=0, fifo_ovf=0, page_set=0, row_add_user=0, col_add_user=0, FIFO emptied, pending high byte cleared.
REQ-033 Reset asserted mid-CLEAR or mid-RUN SHALL abort the operation with no further push, and the clear SHALL restart from page 0.

Verification
REQ-034 H_ACT=4, V_ACT=2, CLR_PAGES=2: 16 startup_inc pulses -> FIFO_out=CLR_VALUE throughout; page_set goes 0 to 1 after pulse 8; startup=1 after pulse 16 with addresses at 0/0/0.
REQ-035 After the clear: bytes A5,03,12,34 -> page_set=3; FIFO_out=16'h1234 with FIFO_full=1 one cycle after the 34 strobe.
REQ-036 Push 9 words with FIFO_DEPTH=8 and no pops -> fifo_ovf=1; pop 8 -> words 1..8 in order, then FIFO_full=0.
REQ-037 Full FIFO with simultaneous push and pop -> no overflow, level stays 8; a pop while empty -> no state change.
REQ-038 In RUN, 7 startup_inc pulses with H_ACT=4 -> col=3,row=1; the 8th -> col=0,row=0; after 8 words are pushed the FSM returns to IDLE and a following 8'h55 is ignored.
REQ-039 Reset asserted mid-RUN with 3 words queued -> the next cycle shows FIFO_full=1 (CLEAR), startup=0, fifo_ovf=0, and all addresses 0.

Source files
------------

// File: rtl/uart_pixel_writer.sv
// UART byte stream to SDRAM pixel writer: clears memory at power-up,
// then packs high/low byte pairs into RGB565 words through a small FIFO.
module uart_pixel_writer #(
    parameter int          H_ACT      = 800,
    parameter int          V_ACT      = 480,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CLR_PAGES  = 1,
    parameter logic [15:0] CLR_VALUE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        startup_inc,
    input  logic        FIFO_RD_req,
    output logic [15:0] FIFO_out,
    output logic        FIFO_full,
    output logic [2:0]  page_set,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic        startup,
    output logic        fifo_ovf
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NPIX = H_ACT * V_ACT;
    localparam int PW   = $clog2(NPIX + 1);

    localparam logic [9:0]    COL_LAST  = 10'(H_ACT - 1);
    localparam logic [8:0]    ROW_LAST  = 9'(V_ACT - 1);
    localparam logic [2:0]    PAGE_LAST = 3'(CLR_PAGES - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PAGE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      page_q, page_d;
    logic [8:0]      row_q, row_d;
    logic [9:0]      col_q, col_d;
    logic            startup_q, startup_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [7:0]      hi_q, hi_d;
    logic            hi_vld_q, hi_vld_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            wr_en;
    logic [15:0]     push_word;

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        row_d     = row_q;
        col_d     = col_q;
        startup_d = startup_q;
        ovf_d     = ovf_q;
        pix_d     = pix_q;
        hi_d      = hi_q;
        hi_vld_d  = hi_vld_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = {hi_q, rx_data};
        pop       = (state_q != S_CLEAR) && FIFO_RD_req && (cnt_q != '0);

        // Address walks raster order on every accepted SDRAM write
        if (startup_inc) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    if (state_q == S_CLEAR) page_d = page_q + 3'd1;
                end else begin
                    row_d = row_q + 9'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end

        case (state_q)
            S_CLEAR: begin
                if (startup_inc && col_q == COL_LAST &&
                    row_q == ROW_LAST && page_q == PAGE_LAST) begin
                    state_d   = S_IDLE;
                    page_d    = '0;
                    startup_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (rx_valid && rx_data == 8'hA5) state_d = S_PAGE;
            end
            S_PAGE: begin
                if (rx_valid) begin
                    page_d   = rx_data[2:0];
                    ovf_d    = 1'b0;
                    pix_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                    hi_vld_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (rx_valid) begin
                    if (!hi_vld_q) begin
                        hi_d     = rx_data;
                        hi_vld_d = 1'b1;
                    end else begin
                        push     = 1'b1;
                        hi_vld_d = 1'b0;
                        pix_d    = pix_q + 1'b1;
                        if (pix_q == PIX_LAST) state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // A pop frees the slot a same-cycle push needs, even when full
        wr_en = push && !(cnt_q == CNT_FULL && !pop);
        if (push && !wr_en) ovf_d = 1'b1;
        if (wr_en) wr_d = wr_q + 1'b1;
        if (pop)   rd_d = rd_q + 1'b1;
        if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            page_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            startup_q <= 1'b0;
            ovf_q     <= 1'b0;
            pix_q     <= '0;
            hi_q      <= '0;
            hi_vld_q  <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            row_q     <= row_d;
            col_q     <= col_d;
            startup_q <= startup_d;
            ovf_q     <= ovf_d;
            pix_q     <= pix_d;
            hi_q      <= hi_d;
            hi_vld_q  <= hi_vld_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_q] <= push_word;
    end

    assign FIFO_out     = (state_q == S_CLEAR) ? CLR_VALUE : mem_q[rd_q];
    assign FIFO_full    = (state_q == S_CLEAR) || (cnt_q != '0);
    assign page_set     = page_q;
    assign row_add_user = row_q;
    assign col_add_user = col_q;
    assign startup      = startup_q;
    assign fifo_ovf     = ovf_q;

endmodule

// File: tb/tb_uart_pixel_writer.sv
// Randomised scoreboard bench for uart_pixel_writer with a small
// raster/queue reference model compared every cycle.
module tb_uart_pixel_writer;

    localparam int          H  = 4;
    localparam int          V  = 2;
    localparam int          D  = 8;
    localparam int          CP = 2;
    localparam logic [15:0] CV = 16'hBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        startup_inc = 1'b0;
    logic        FIFO_RD_req = 1'b0;
    logic [15:0] FIFO_out;
    logic        FIFO_full;
    logic [2:0]  page_set;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    logic        startup;
    logic        fifo_ovf;

    uart_pixel_writer #(
        .H_ACT(H), .V_ACT(V), .FIFO_DEPTH(D),
        .CLR_PAGES(CP), .CLR_VALUE(CV)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .startup_inc(startup_inc), .FIFO_RD_req(FIFO_RD_req),
        .FIFO_out(FIFO_out), .FIFO_full(FIFO_full), .page_set(page_set),
        .row_add_user(row_add_user), .col_add_user(col_add_user),
        .startup(startup), .fifo_ovf(fifo_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          exp_startup = 1'b0;
    int          lin = 0;
    int          exp_page = 0;
    bit          exp_ovf = 1'b0;
    logic [15:0] sb [$];

    // Stimulus-to-model hand-off for the current cycle
    bit          push_now = 1'b0;
    logic [15:0] push_word = '0;
    bit          page_now = 1'b0;
    logic [2:0]  page_val = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_startup = 1'b0;
            lin         = 0;
            exp_page    = 0;
            exp_ovf     = 1'b0;
            sb.delete();
        end else begin
            bit pop;
            bit was_full;
            chk("startup", int'(startup), int'(exp_startup));
            chk("col", int'(col_add_user), lin % H);
            chk("row", int'(row_add_user), (lin / H) % V);
            chk("page", int'(page_set), exp_startup ? exp_page : lin / (H * V));
            chk("fifo_ovf", int'(fifo_ovf), int'(exp_ovf));
            chk("FIFO_full", int'(FIFO_full), exp_startup ? int'(sb.size() != 0) : 1);
            if (!exp_startup) chk("clr_out", int'(FIFO_out), int'(CV));
            else if (sb.size() > 0) chk("FIFO_out", int'(FIFO_out), int'(sb[0]));

            pop      = FIFO_RD_req && exp_startup && sb.size() > 0;
            was_full = sb.size() == D;
            if (pop) void'(sb.pop_front());
            if (page_now) begin
                exp_page = int'(page_val);
                lin      = 0;
                exp_ovf  = 1'b0;
            end else if (startup_inc) begin
                if (!exp_startup) begin
                    lin++;
                    if (lin == H * V * CP) begin
                        lin         = 0;
                        exp_startup = 1'b1;
                        exp_page    = 0;
                    end
                end else begin
                    lin = (lin + 1) % (H * V);
                end
            end
            if (push_now) begin
                if (was_full && !pop) exp_ovf = 1'b1;
                else sb.push_back(push_word);
            end
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit psh,
                        input logic [15:0] w, input bit pg,
                        input int pop_pct, input int inc_pct);
        rx_valid    = v;
        rx_data     = d;
        push_now    = psh;
        push_word   = w;
        page_now    = pg;
        page_val    = d[2:0];
        startup_inc = !pg && (int'($urandom_range(99)) < inc_pct);
        FIFO_RD_req = int'($urandom_range(99)) < pop_pct;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int pop_pct, input int inc_pct);
        step(1'b0, 8'h00, 1'b0, 16'h0, 1'b0, pop_pct, inc_pct);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit psh,
                             input logic [15:0] w, input bit pg,
                             input int pop_gap, input int pop_b, input int inc);
        int gap = int'($urandom_range(2));
        for (int i = 0; i < gap; i++) idle(pop_gap, inc);
        step(1'b1, b, psh, w, pg, pop_b, inc);
    endtask

    task automatic send_word(input logic [15:0] w, input int pop_gap,
                             input int pop_lo, input int inc);
        send_byte(w[15:8], 1'b0, 16'h0, 1'b0, pop_gap, pop_gap, inc);
        send_byte(w[7:0], 1'b1, w, 1'b0, pop_gap, pop_lo, inc);
    endtask

    task automatic start_frame(input logic [7:0] pb, input int pop, input int inc);
        send_byte(8'hA5, 1'b0, 16'h0, 1'b0, pop, pop, inc);
        send_byte(pb, 1'b0, 16'h0, 1'b1, pop, pop, inc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(50, 50);
        rst = 1'b0;
    endtask

    task automatic wait_clear();
        int k = 0;
        while (!exp_startup && k < 500) begin
            step(1'($urandom), 8'($urandom), 1'b0, 16'h0, 1'b0, 50, 50);
            k++;
        end
        if (!exp_startup) begin
            n_checks++;
            n_fail++;
            $display("FAIL clear_timeout: startup got 0 expected 1");
        end
    endtask

    initial begin
        repeat (2) idle(0, 0);
        rst = 1'b0;

        // Partial clear, then reset restarts it from page 0
        for (int i = 0; i < 12; i++) idle(50, 60);
        do_reset();
        wait_clear();

        // Directed frame on page 3: first word 1234
        start_frame(8'h03, 0, 40);
        send_word(16'h1234, 0, 0, 40);
        for (int i = 0; i < 7; i++) send_word(16'($urandom), 30, 30, 40);
        for (int i = 0; i < 12; i++) idle(100, 40);

        // Fill to 8, push+pop at full, overflow, drain, pop while empty
        start_frame(8'h01, 0, 30);
        for (int i = 0; i < 8; i++) send_word(16'h1000 + 16'(i), 0, 0, 30);
        start_frame(8'h02, 0, 30);
        send_word(16'h2001, 0, 100, 30);
        send_word(16'h2002, 0, 0, 30);
        for (int i = 0; i < 12; i++) idle(100, 30);
        for (int i = 0; i < 6; i++) send_word(16'h2100 + 16'(i), 0, 0, 30);
        for (int i = 0; i < 12; i++) idle(100, 30);

        // Junk in IDLE, including 55 right after a frame
        send_byte(8'h55, 1'b0, 16'h0, 1'b0, 50, 50, 50);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] j = 8'($urandom);
            if (j == 8'hA5) j = 8'h55;
            send_byte(j, 1'b0, 16'h0, 1'b0, 50, 50, 50);
        end

        // Random frames
        for (int f = 0; f < 15; f++) begin
            int pp = int'($urandom_range(100));
            int ip = int'($urandom_range(100));
            start_frame(8'($urandom), pp, ip);
            for (int i = 0; i < H * V; i++) send_word(16'($urandom), pp, pp, ip);
            for (int i = 0; i < 4; i++) idle(pp, ip);
        end
        for (int i = 0; i < 12; i++) idle(100, 50);

        // Reset with 3 words queued mid-frame
        start_frame(8'h05, 0, 50);
        for (int i = 0; i < 3; i++) send_word(16'($urandom), 0, 0, 50);
        do_reset();
        wait_clear();
        start_frame(8'h07, 50, 50);
        for (int i = 0; i < H * V; i++) send_word(16'($urandom), 50, 50, 50);
        for (int i = 0; i < 12; i++) idle(100, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
